// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART types and constants (receive and transmit sides).
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Deframer states; PARITY is only reached when parity support is built in
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam logic [15:0] WTIME_DEFAULT = 16'h0364;
    localparam int          DATA_BITS     = 8;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO with registered head; a push into a full FIFO
//             is accepted only when a pop happens in the same cycle, otherwise
//             it is dropped and flagged on o_overrun.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_valid,
    output logic             o_overrun
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_cw'(DEPTH));
    assign w_pop      = i_pop & ~w_empty;
    assign w_push     = i_push & (~w_full | w_pop);
    assign o_overrun  = i_push & w_full & ~w_pop;
    assign o_valid    = ~w_empty;
    // Head is forced to zero while empty so a reset FIFO presents 0
    assign o_pop_data = w_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents need no reset because the count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frame
//  Brief    : UART receiver (8 data bits, LSB first, 1 stop bit, idle high)
//             feeding a valid/ready stream through a small output FIFO.
//             Build option UART_RX_PARITY_EN adds an even-parity bit between
//             the data and the stop bit; mismatches drop the byte and pulse
//             o_frame_err.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter logic [15:0] WTIME      = WTIME_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       uart_txd_in,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       o_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    // Half-bit sample point for the start bit, full-bit for everything after
    localparam logic [15:0] c_half_last = (WTIME >> 1) - 16'd1;
    localparam logic [15:0] c_full_last = WTIME - 16'd1;
    localparam logic [2:0]  c_idx_last  = 3'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [15:0]          r_cnt;
    logic [2:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;

    logic w_rx;
    logic w_cnt_clr;
    logic w_shift_en;
    logic w_par_chk;
    logic w_par_err;
    logic w_push;
    logic w_ferr;
    logic w_bit_done;

    assign w_rx       = r_sync2;
    assign w_bit_done = (r_cnt == c_full_last);

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_txd_in;
            r_sync2 <= r_sync1;
        end
    end

    // State register with bit-time counter, bit index and data shifter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_clr ? 16'd0 : r_cnt + 16'd1;
            if (r_state != DATA) begin
                r_idx <= '0;
            end else if (w_shift_en) begin
                r_idx <= r_idx + 3'd1;
            end
            // LSB arrives first, so shifting in from the top lands it at bit 0
            if (w_shift_en) begin
                r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_err;

    // Even parity: data ones plus parity bit must be even
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_par_err <= 1'b0;
        end else if (r_state == IDLE) begin
            r_par_err <= 1'b0;
        end else if (w_par_chk) begin
            r_par_err <= (^r_shift) ^ w_rx;
        end
    end

    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    // Next-state and per-cycle strobes of the deframer
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_par_chk   = 1'b0;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rx) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch
                if (r_cnt == c_half_last) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = w_rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_idx == c_idx_last) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_bit_done) begin
                    w_cnt_clr   = 1'b1;
                    w_par_chk   = 1'b1;
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                // Returning to IDLE mid-stop-bit re-arms for a back-to-back frame
                if (w_bit_done) begin
                    w_cnt_clr = 1'b1;
                    if (!w_rx) begin
                        w_ferr      = 1'b1;
                        w_state_nxt = BREAK;
                    end else if (w_par_err) begin
                        w_ferr      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_push      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            BREAK: begin
                // Hold off new starts until the line has gone back high
                w_cnt_clr = 1'b1;
                if (w_rx) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_frame_err = w_ferr;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .nrst        (nrst),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop       (o_ready),
        .o_pop_data  (o_data),
        .o_valid     (o_valid),
        .o_overrun   (o_overrun)
    );

endmodule
`default_nettype wire
